// File: rtl/imager_multilane.sv
// Synthetic multi-lane image sensor. It emits LANES pixels per clock with fv/lv/sync
// framing and four test patterns. Geometry, sync window and noise seed are copied
// into shadow registers at each frame start, so reconfiguring mid-frame is harmless.
// Pattern mode and the bayer values are read live on every cycle.
module imager_multilane #(
   parameter int DATA_WIDTH     = 10,
   parameter int LANES          = 2,
   parameter int NUM_ROWS_WIDTH = 12,
   parameter int NUM_COLS_WIDTH = 12
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic                          single_frame,
   input  logic [1:0]                    mode,
   input  logic [DATA_WIDTH-1:0]         bayer_red,
   input  logic [DATA_WIDTH-1:0]         bayer_gr,
   input  logic [DATA_WIDTH-1:0]         bayer_gb,
   input  logic [DATA_WIDTH-1:0]         bayer_blue,
   input  logic [NUM_ROWS_WIDTH-1:0]     num_active_rows,
   input  logic [NUM_ROWS_WIDTH-1:0]     num_virtual_rows,
   input  logic [NUM_COLS_WIDTH-1:0]     num_active_cols,
   input  logic [NUM_COLS_WIDTH-1:0]     num_virtual_cols,
   input  logic [NUM_ROWS_WIDTH-1:0]     sync_row_start,
   input  logic [NUM_ROWS_WIDTH-1:0]     sync_rows,
   input  logic [31:0]                   noise_seed,
   output logic [LANES*DATA_WIDTH-1:0]   dat,
   output logic                          fv,
   output logic                          lv,
   output logic                          sync,
   output logic [15:0]                   frame_count,
   output logic                          cfg_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FRAME = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // One extra bit so active+virtual totals and the sync window end never wrap.
   localparam int RW = NUM_ROWS_WIDTH + 1;
   localparam int CW = NUM_COLS_WIDTH + 1;

   logic [1:0]                  state;
   logic [RW-1:0]               row;
   logic [CW-1:0]               col;
   logic [31:0]                 lfsr;

   logic [NUM_ROWS_WIDTH-1:0]   sh_act_rows, sh_virt_rows, sh_sync_start, sh_sync_rows;
   logic [NUM_COLS_WIDTH-1:0]   sh_act_cols, sh_virt_cols;

   logic [RW-1:0]               total_rows, sync_end;
   logic [CW-1:0]               total_cols;
   logic [CW:0]                 col_next;
   logic                        in_frame, last_group, frame_end, start_req, cfg_ok, load;
   logic                        fv_c, lv_c, sync_c;
   logic [LANES*DATA_WIDTH-1:0] dat_c;

   assign total_rows = {1'b0, sh_act_rows} + {1'b0, sh_virt_rows};
   assign total_cols = {1'b0, sh_act_cols} + {1'b0, sh_virt_cols};
   assign sync_end   = {1'b0, sh_sync_start} + {1'b0, sh_sync_rows};
   assign col_next   = {1'b0, col} + (CW+1)'(LANES);

   assign in_frame   = (state == ST_FRAME);
   assign last_group = (col_next >= {1'b0, total_cols});
   assign frame_end  = in_frame && last_group && (row == total_rows - RW'(1));

   // A start is requested when enable is seen in IDLE, or at a frame end in free-run.
   // The config is accepted only when it describes a non-empty picture.
   assign start_req  = ((state == ST_IDLE) && enable) || (frame_end && enable && !single_frame);
   assign cfg_ok     = (num_active_rows != '0) && (num_active_cols != '0);
   assign load       = start_req && cfg_ok;

   assign fv_c   = in_frame && (row < {1'b0, sh_act_rows});
   assign lv_c   = fv_c && (col < {1'b0, sh_act_cols});
   assign sync_c = in_frame && (row >= {1'b0, sh_sync_start}) && (row < sync_end);

   // Pixel values for every lane at the current position. Blanking cycles produce zero.
   always_comb begin
      // NOTE: the default assignment comes first, so every path drives dat_c and no latch is inferred.
      dat_c = '0;
      if (lv_c) begin
         for (int k = 0; k < LANES; k++) begin
            case (mode)
               2'd0: begin
                  case ({row[0], col[0] ^ k[0]})
                     2'b00:   dat_c[k*DATA_WIDTH +: DATA_WIDTH] = bayer_red;
                     2'b01:   dat_c[k*DATA_WIDTH +: DATA_WIDTH] = bayer_gr;
                     2'b10:   dat_c[k*DATA_WIDTH +: DATA_WIDTH] = bayer_gb;
                     default: dat_c[k*DATA_WIDTH +: DATA_WIDTH] = bayer_blue;
                  endcase
               end
               2'd1:    dat_c[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(col + CW'(k));
               2'd2:    dat_c[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'({lfsr, lfsr} >> (7 * k));
               default: dat_c[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(col + CW'(k))
                                                           + DATA_WIDTH'(row) + DATA_WIDTH'(frame_count);
            endcase
         end
      end
   end

   // Sequencer: state, raster position, LFSR, frame counter and the sticky config error.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: all state updates use <= so each register samples pre-edge values, whatever the statement order.
      if (!reset_n) begin
         state       <= ST_IDLE;
         row         <= '0;
         col         <= '0;
         lfsr        <= 32'd1;
         frame_count <= '0;
         cfg_err     <= 1'b0;
      end else begin
         if (frame_end)
            frame_count <= frame_count + 16'd1;
         if (load) begin
            state   <= ST_FRAME;
            row     <= '0;
            col     <= '0;
            lfsr    <= (noise_seed == 32'd0) ? 32'd1 : noise_seed;
            cfg_err <= 1'b0;
         end else begin
            if (start_req)
               cfg_err <= 1'b1;
            if (lv_c)
               lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
            if (in_frame) begin
               if (last_group) begin
                  col <= '0;
                  row <= frame_end ? '0 : row + RW'(1);
               end else begin
                  col <= col_next[CW-1:0];
               end
            end
            case (state)
               ST_IDLE:  ;
               ST_FRAME: if (frame_end) state <= (enable && single_frame) ? ST_DONE : ST_IDLE;
               ST_DONE:  if (!enable) state <= ST_IDLE;
               default:  state <= ST_IDLE;
            endcase
         end
      end
   end

   // Shadow copies of the frame-latched configuration.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_act_rows   <= '0;
         sh_virt_rows  <= '0;
         sh_act_cols   <= '0;
         sh_virt_cols  <= '0;
         sh_sync_start <= '0;
         sh_sync_rows  <= '0;
      end else if (load) begin
         sh_act_rows   <= num_active_rows;
         sh_virt_rows  <= num_virtual_rows;
         sh_act_cols   <= num_active_cols;
         sh_virt_cols  <= num_virtual_cols;
         sh_sync_start <= sync_row_start;
         sh_sync_rows  <= sync_rows;
      end
   end

   // Registered outputs. They are all low whenever no frame is in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dat  <= '0;
         fv   <= 1'b0;
         lv   <= 1'b0;
         sync <= 1'b0;
      end else begin
         dat  <= dat_c;
         fv   <= fv_c;
         lv   <= lv_c;
         sync <= sync_c;
      end
   end

endmodule

// File: tb/tb_imager_multilane.sv
// Bench for imager_multilane. It drives a 2-lane and a 4-lane instance and compares
// both against a frame-position reference model on every cycle. Directed steps
// cover the framing and control scenarios. Randomized frames with live mode
// changes follow them.
module tb_imager_multilane;

   localparam int DW  = 10;
   localparam int RWD = 12;
   localparam int CWD = 12;

   logic            clk = 1'b0;
   logic            reset_n, enable, single_frame;
   logic [1:0]      mode;
   logic [DW-1:0]   bayer_red, bayer_gr, bayer_gb, bayer_blue;
   logic [31:0]     noise_seed;
   logic [RWD-1:0]  act_rows [2], virt_rows [2], sync_start [2], sync_rows [2];
   logic [CWD-1:0]  act_cols [2], virt_cols [2];

   logic [2*DW-1:0] dat2;
   logic [4*DW-1:0] dat4;
   logic            fv2, lv2, sync2, err2, fv4, lv4, sync4, err4;
   logic [15:0]     fc2, fc4;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   imager_multilane #(.DATA_WIDTH(DW), .LANES(2), .NUM_ROWS_WIDTH(RWD), .NUM_COLS_WIDTH(CWD)) dut2 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .single_frame(single_frame), .mode(mode),
      .bayer_red(bayer_red), .bayer_gr(bayer_gr), .bayer_gb(bayer_gb), .bayer_blue(bayer_blue),
      .num_active_rows(act_rows[0]), .num_virtual_rows(virt_rows[0]),
      .num_active_cols(act_cols[0]), .num_virtual_cols(virt_cols[0]),
      .sync_row_start(sync_start[0]), .sync_rows(sync_rows[0]), .noise_seed(noise_seed),
      .dat(dat2), .fv(fv2), .lv(lv2), .sync(sync2), .frame_count(fc2), .cfg_err(err2));

   imager_multilane #(.DATA_WIDTH(DW), .LANES(4), .NUM_ROWS_WIDTH(RWD), .NUM_COLS_WIDTH(CWD)) dut4 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .single_frame(single_frame), .mode(mode),
      .bayer_red(bayer_red), .bayer_gr(bayer_gr), .bayer_gb(bayer_gb), .bayer_blue(bayer_blue),
      .num_active_rows(act_rows[1]), .num_virtual_rows(virt_rows[1]),
      .num_active_cols(act_cols[1]), .num_virtual_cols(virt_cols[1]),
      .sync_row_start(sync_start[1]), .sync_rows(sync_rows[1]), .noise_seed(noise_seed),
      .dat(dat4), .fv(fv4), .lv(lv4), .sync(sync4), .frame_count(fc4), .cfg_err(err4));

   // Reference model. A running frame is a single cycle index 'pos'. Row and column
   // are derived from it by division, and the outputs follow from the framing rules.
   typedef struct {
      bit          run;
      bit          done;
      bit          err;
      int          pos;
      int          ar, vr, ac, vc, ss, sr;
      int unsigned lfsr;
      int          fc;
      logic [63:0] edat;
      bit          efv, elv, esync;
   } model_t;

   model_t m [2];

   function automatic int unsigned lfsr_step(input int unsigned x);
      return {x[30:0], ^(x & 32'h8020_0003)};
   endfunction

   function automatic int unsigned ror(input int unsigned x, input int s);
      return (x >> s) | (x << (32 - s));
   endfunction

   task automatic model_reset();
      model_t z;
      z.run = 0; z.done = 0; z.err = 0; z.pos = 0; z.fc = 0; z.lfsr = 1;
      z.ar = 0; z.vr = 0; z.ac = 0; z.vc = 0; z.ss = 0; z.sr = 0;
      z.edat = '0; z.efv = 0; z.elv = 0; z.esync = 0;
      m[0] = z;
      m[1] = z;
   endtask

   task automatic try_start(inout model_t s, input int i);
      if (act_rows[i] == '0 || act_cols[i] == '0) begin
         s.err = 1;
      end else begin
         s.ar = int'(act_rows[i]);   s.vr = int'(virt_rows[i]);
         s.ac = int'(act_cols[i]);   s.vc = int'(virt_cols[i]);
         s.ss = int'(sync_start[i]); s.sr = int'(sync_rows[i]);
         s.lfsr = (noise_seed == 32'd0) ? 32'd1 : noise_seed;
         s.err = 0;
         s.run = 1;
         s.pos = 0;
      end
   endtask

   task automatic model_step(input int i);
      model_t      s = m[i];
      int          lanes = (i == 0) ? 2 : 4;
      int          gpr, total, r, c, p;
      int unsigned v;
      s.edat = '0; s.efv = 0; s.elv = 0; s.esync = 0;
      if (s.run) begin
         gpr   = (s.ac + s.vc) / lanes;
         total = gpr * (s.ar + s.vr);
         r     = s.pos / gpr;
         c     = (s.pos % gpr) * lanes;
         s.efv   = (r < s.ar);
         s.elv   = s.efv && (c < s.ac);
         s.esync = (r >= s.ss) && (r < s.ss + s.sr);
         if (s.elv) begin
            for (int k = 0; k < lanes; k++) begin
               p = c + k;
               case (mode)
                  2'd0:    v = (r % 2 == 0) ? ((p % 2 == 0) ? bayer_red : bayer_gr)
                                            : ((p % 2 == 0) ? bayer_gb  : bayer_blue);
                  2'd1:    v = p;
                  2'd2:    v = ror(s.lfsr, 7 * k);
                  default: v = p + r + s.fc;
               endcase
               s.edat[k*DW +: DW] = DW'(v);
            end
            s.lfsr = lfsr_step(s.lfsr);
         end
         s.pos++;
         if (s.pos == total) begin
            s.fc  = (s.fc + 1) % 65536;
            s.run = 0;
            if (enable && !single_frame) try_start(s, i);
            else if (enable)             s.done = 1;
         end
      end else if (s.done) begin
         if (!enable) s.done = 0;
      end else if (enable) begin
         try_start(s, i);
      end
      m[i] = s;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else begin
         model_step(0);
         model_step(1);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: wait for the falling edge, then compare both instances with the model.
   task automatic cyc();
      @(negedge clk);
      check("fv2",   64'(fv2),   64'(m[0].efv));
      check("lv2",   64'(lv2),   64'(m[0].elv));
      check("sync2", 64'(sync2), 64'(m[0].esync));
      check("dat2",  64'(dat2),  m[0].edat);
      check("fc2",   64'(fc2),   64'(m[0].fc));
      check("err2",  64'(err2),  64'(m[0].err));
      check("fv4",   64'(fv4),   64'(m[1].efv));
      check("lv4",   64'(lv4),   64'(m[1].elv));
      check("sync4", 64'(sync4), 64'(m[1].esync));
      check("dat4",  64'(dat4),  m[1].edat);
      check("fc4",   64'(fc4),   64'(m[1].fc));
      check("err4",  64'(err4),  64'(m[1].err));
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic set_geo(input int i, input int ar, input int vr, input int ac, input int vc,
                          input int ss, input int sr);
      act_rows[i]   = RWD'(ar);
      virt_rows[i]  = RWD'(vr);
      act_cols[i]   = CWD'(ac);
      virt_cols[i]  = CWD'(vc);
      sync_start[i] = RWD'(ss);
      sync_rows[i]  = RWD'(sr);
   endtask

   initial begin
      int              nfv, nlv, n4, fc_base, seen_fv;
      logic [2*DW-1:0] d_first, d_row1;
      logic [4*DW-1:0] g0, g1, e0, e1;
      int              ar, vr, ss, sr;

      model_reset();
      reset_n = 1'b0; enable = 1'b0; single_frame = 1'b0; mode = 2'd0;
      bayer_red = '0; bayer_gr = '0; bayer_gb = '0; bayer_blue = '0; noise_seed = '0;
      set_geo(0, 2, 1, 4, 2, 1, 1);
      set_geo(1, 2, 1, 8, 4, 1, 1);
      run(2);
      check("reset_dat2", 64'(dat2), 64'd0);
      check("reset_fc2",  64'(fc2),  64'd0);
      reset_n = 1'b1;
      run(1);

      // Bayer solid, single frame: 2 active rows of 4 pixels, 2 h-blank pixels, 1 virtual row.
      mode = 2'd0; bayer_red = 10'd1; bayer_gr = 10'd2; bayer_gb = 10'd3; bayer_blue = 10'd4;
      single_frame = 1'b1; enable = 1'b1;
      nfv = 0; nlv = 0; d_first = '0; d_row1 = '0;
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (fv2) nfv++;
         if (lv2) begin
            nlv++;
            if (nlv == 1) d_first = dat2;
            if (nlv == 3) d_row1  = dat2;
         end
      end
      check("t1_fv_cycles", 64'(nfv), 64'd6);
      check("t1_lv_cycles", 64'(nlv), 64'd4);
      check("t1_row0_dat",  64'(d_first), 64'((2 << DW) | 1));
      check("t1_row1_dat",  64'(d_row1),  64'((4 << DW) | 3));
      check("t1_frames",    64'(fc2), 64'd1);
      enable = 1'b0;
      run(2);

      // Horizontal ramp on four lanes.
      mode = 2'd1; enable = 1'b1; n4 = 0; g0 = '0; g1 = '0; e0 = '0; e1 = '0;
      for (int k = 0; k < 4; k++) begin
         e0[k*DW +: DW] = DW'(k);
         e1[k*DW +: DW] = DW'(k + 4);
      end
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (lv4) begin
            n4++;
            if (n4 == 1) g0 = dat4;
            if (n4 == 2) g1 = dat4;
         end
      end
      check("t2_group0", 64'(g0), 64'(e0));
      check("t2_group1", 64'(g1), 64'(e1));
      enable = 1'b0;
      run(2);

      // Enable dropped at row 1 of a 3-row frame. The frame still completes, with no restart.
      single_frame = 1'b0; mode = 2'd3;
      set_geo(0, 3, 1, 4, 2, 1, 2);
      set_geo(1, 3, 1, 8, 4, 1, 2);
      fc_base = m[0].fc;
      enable = 1'b1;
      run(6);
      enable = 1'b0;
      run(14);
      check("t3_frames", 64'(fc2), 64'(fc_base + 1));
      check("t3_fv_low", 64'(fv2), 64'd0);

      // Single-shot with enable held for three frame times, then an enable toggle.
      single_frame = 1'b1; mode = 2'd0;
      fc_base = m[0].fc;
      enable = 1'b1;
      run(40);
      check("t4_one_frame", 64'(fc2), 64'(fc_base + 1));
      enable = 1'b0;
      run(1);
      enable = 1'b1;
      run(14);
      check("t4_two_frames", 64'(fc2), 64'(fc_base + 2));
      enable = 1'b0;
      run(2);

      // LFSR noise: seed 0, then seed 1, then a free-running burst that repeats one seed.
      mode = 2'd2; noise_seed = 32'd0; enable = 1'b1;
      run(14);
      enable = 1'b0; run(2);
      noise_seed = 32'd1; enable = 1'b1;
      run(14);
      enable = 1'b0; run(2);
      single_frame = 1'b0; noise_seed = 32'hACE1_2345; enable = 1'b1;
      run(26);
      enable = 1'b0;
      run(14);

      // Zero active columns: no frame starts, cfg_err is raised, then a valid config clears it.
      set_geo(0, 3, 1, 0, 2, 1, 2);
      enable = 1'b1;
      seen_fv = 0;
      for (int c = 0; c < 5; c++) begin
         cyc();
         if (fv2) seen_fv++;
      end
      check("t6_no_fv",  64'(seen_fv), 64'd0);
      check("t6_err_on", 64'(err2), 64'd1);
      set_geo(0, 3, 1, 4, 2, 1, 2);
      run(2);
      check("t6_err_off", 64'(err2), 64'd0);
      check("t6_fv_up",   64'(fv2),  64'd1);
      enable = 1'b0;
      run(16);

      // Reset in the middle of a frame.
      enable = 1'b1;
      run(5);
      reset_n = 1'b0;
      run(1);
      check("rst_mid_fc", 64'(fc2), 64'd0);
      check("rst_mid_fv", 64'(fv2), 64'd0);
      reset_n = 1'b1; enable = 1'b0;
      run(2);

      // Randomized geometry, patterns, seeds and enable activity, with mode changed mid-frame.
      for (int it = 0; it < 8; it++) begin
         ar = $urandom_range(0, 3); vr = $urandom_range(0, 2);
         ss = $urandom_range(0, 4); sr = $urandom_range(0, 3);
         set_geo(0, ar, vr, 2 * $urandom_range(0, 3), 2 * $urandom_range(0, 2), ss, sr);
         set_geo(1, ar, vr, 4 * $urandom_range(1, 2), 4 * $urandom_range(0, 1), ss, sr);
         mode = 2'($urandom);
         bayer_red = DW'($urandom); bayer_gr   = DW'($urandom);
         bayer_gb  = DW'($urandom); bayer_blue = DW'($urandom);
         noise_seed   = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
         single_frame = 1'($urandom);
         for (int c = 0; c < 40; c++) begin
            enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            cyc();
         end
      end
      enable = 1'b0;
      run(30);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
